// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: PID constants and state encodings shared by the USB full-speed protocol engines
package usb_fs_pkg;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  typedef enum logic [1:0] {EP_FILLING, EP_READY, EP_STALL} ep_state_t;
  typedef enum logic [1:0] {XFER_IDLE, XFER_RCVD_IN, XFER_SEND_DATA, XFER_WAIT_ACK} xfer_state_t;
endpackage

// File: rtl/usb_fs_in_ep_buf.sv
// usb_fs_in_ep_buf: endpoint-indexed byte RAM, one synchronous write port, one combinational read port
module usb_fs_in_ep_buf #(
  parameter int NUM_EPS = 1,
  parameter int SIZE = 32,
  localparam int OW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    w_ep,
  input  logic [OW-1:0] w_off,
  input  logic [7:0]    w_data,
  input  logic [3:0]    r_ep,
  input  logic [OW-1:0] r_off,
  output logic [7:0]    r_data
);
  localparam int DEPTH = NUM_EPS * SIZE;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] w_addr, r_addr;
  assign w_addr = AW'(32'(w_ep) * 32'(SIZE) + 32'(w_off));
  assign r_addr = AW'(32'(r_ep) * 32'(SIZE) + 32'(r_off));
  assign r_data = mem[r_addr];
  // byte store; contents are don't-care until written
  always_ff @(posedge clk)
    if (we) mem[w_addr] <= w_data;
endmodule

// File: rtl/usb_fs_in_pe.sv
// usb_fs_in_pe: USB full-speed IN protocol engine with per-endpoint packet buffers
module usb_fs_in_pe
  import usb_fs_pkg::*;
#(
  parameter int NUM_IN_EPS = 1,
  parameter int MAX_IN_PACKET_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  input  logic                  rx_pkt_start,
  input  logic                  rx_pkt_end,
  input  logic                  rx_pkt_valid,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  output logic                  tx_pkt_start,
  output logic [3:0]            tx_pid,
  input  logic                  tx_pkt_end,
  output logic                  tx_data_avail,
  input  logic                  tx_data_get,
  output logic [7:0]            tx_data
);
  localparam int OW = $clog2(MAX_IN_PACKET_SIZE);
  localparam int PW = OW + 1;
  localparam logic [PW-1:0] FULL = PW'(MAX_IN_PACKET_SIZE);
  ep_state_t ep_state [NUM_IN_EPS];
  logic [PW-1:0] put_ptr [NUM_IN_EPS];
  logic [NUM_IN_EPS-1:0] toggle;
  xfer_state_t state, next_state;
  logic [3:0] current_endp;
  logic [PW-1:0] get_ptr;
  logic [9:0] timer;
  ep_state_t cur_state;
  logic [PW-1:0] cur_put;
  logic cur_toggle, cur_reset, we, tok_ok, in_tok, setup_tok, ack_ok;
  logic [3:0] w_ep;
  logic [OW-1:0] w_off;
  logic [7:0] rd_data;
  assign tok_ok = rx_pkt_end & rx_pkt_valid & (rx_addr == dev_addr);
  assign in_tok = tok_ok & (rx_pid == PID_IN) & (32'(rx_endp) < 32'(NUM_IN_EPS));
  assign setup_tok = tok_ok & (rx_pid == PID_SETUP);
  assign tx_data_avail = (state == XFER_SEND_DATA) & (get_ptr < cur_put);
  assign tx_data = state == XFER_SEND_DATA ? rd_data : 8'h00;
  // select the active endpoint's context, steer buffer writes, and decode per-endpoint outputs
  always_comb begin
    cur_state = EP_FILLING;
    cur_put = '0;
    cur_toggle = 1'b0;
    cur_reset = 1'b0;
    we = 1'b0;
    w_ep = 4'h0;
    w_off = '0;
    in_ep_data_free = '0;
    in_ep_acked = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (current_endp == 4'(i)) begin
        cur_state = ep_state[i];
        cur_put = put_ptr[i];
        cur_toggle = toggle[i];
        cur_reset = reset_ep[i];
        in_ep_acked[i] = ack_ok;
      end
      if (in_ep_data_put[i] && ep_state[i] == EP_FILLING && put_ptr[i] < FULL) begin
        we = 1'b1;
        w_ep = 4'(i);
        w_off = put_ptr[i][OW-1:0];
      end
      in_ep_data_free[i] = ep_state[i] == EP_FILLING;
    end
  end
  // per-endpoint state: fill, arm, stall, and recycle after an acknowledged packet
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_IN_EPS; i++)
      if (reset | reset_ep[i]) begin
        ep_state[i] <= EP_FILLING;
        put_ptr[i] <= '0;
        toggle[i] <= 1'b0;
      end else if (in_ep_stall[i]) begin
        ep_state[i] <= EP_STALL;
      end else if (setup_tok && rx_endp == 4'(i) && ep_state[i] == EP_STALL) begin
        ep_state[i] <= EP_FILLING;
        put_ptr[i] <= '0;
        toggle[i] <= 1'b0;
      end else if (in_ep_acked[i]) begin
        ep_state[i] <= EP_FILLING;
        put_ptr[i] <= '0;
        toggle[i] <= ~toggle[i];
      end else if (ep_state[i] == EP_FILLING) begin
        if (in_ep_data_put[i] && put_ptr[i] < FULL) put_ptr[i] <= put_ptr[i] + 1'b1;
        if (in_ep_data_done[i]) ep_state[i] <= EP_READY;
      end
  // transfer sequencing: answer the IN token, stream payload, await the host handshake
  always_comb begin
    next_state = state;
    tx_pkt_start = 1'b0;
    tx_pid = 4'h0;
    ack_ok = 1'b0;
    case (state)
      XFER_IDLE: next_state = in_tok ? XFER_RCVD_IN : XFER_IDLE;
      XFER_RCVD_IN: begin
        tx_pkt_start = 1'b1;
        tx_pid = cur_state == EP_STALL ? PID_STALL : cur_state == EP_FILLING ? PID_NAK : cur_toggle ? PID_DATA1 : PID_DATA0;
        next_state = cur_state == EP_READY ? XFER_SEND_DATA : XFER_IDLE;
      end
      XFER_SEND_DATA: next_state = cur_reset ? XFER_IDLE : tx_pkt_end ? XFER_WAIT_ACK : XFER_SEND_DATA;
      XFER_WAIT_ACK: begin
        ack_ok = ~cur_reset & rx_pkt_end & rx_pkt_valid & (rx_pid == PID_ACK);
        next_state = (cur_reset | rx_pkt_end | (timer == 10'd1022)) ? XFER_IDLE : XFER_WAIT_ACK;
      end
    endcase
  end
  // transfer registers; the handshake timeout pauses while a host packet is arriving
  always_ff @(posedge clk)
    if (reset) begin
      state <= XFER_IDLE;
      current_endp <= 4'h0;
      get_ptr <= '0;
      timer <= 10'd0;
    end else begin
      state <= next_state;
      if (state == XFER_IDLE && in_tok) current_endp <= rx_endp;
      get_ptr <= state == XFER_RCVD_IN ? '0 : get_ptr + PW'(tx_data_get & tx_data_avail);
      timer <= state != XFER_WAIT_ACK ? 10'd0 : rx_pkt_start ? timer : timer + 10'd1;
    end
  usb_fs_in_ep_buf #(.NUM_EPS(NUM_IN_EPS), .SIZE(MAX_IN_PACKET_SIZE)) u_buf (
    .clk(clk),
    .we(we),
    .w_ep(w_ep),
    .w_off(w_off),
    .w_data(in_ep_data),
    .r_ep(current_endp),
    .r_off(get_ptr[OW-1:0]),
    .r_data(rd_data)
  );
endmodule

// File: doc/usb_fs_in_pe.md
USB_FS_IN_PE -- requirements
Module: usb_fs_in_pe

Interface
REQ-001 The block SHALL take parameter NUM_IN_EPS, default 1, meaning the number of IN endpoints (1..16).
REQ-002 The block SHALL take parameter MAX_IN_PACKET_SIZE, default 32, meaning the bytes per endpoint buffer (power of two, max 64).
REQ-003 clk  in  1  clock; reset is synchronous, active-high, named reset.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 reset_ep  in  NUM_IN_EPS  per-endpoint reset (bus reset / set-config).
REQ-006 dev_addr  in  7  assigned device address.
REQ-007 in_ep_data_free  out  NUM_IN_EPS  endpoint buffer may be written.
REQ-008 in_ep_data_put  in  NUM_IN_EPS  one-hot byte write strobe.
REQ-009 in_ep_data  in  8  byte written on put.
REQ-010 in_ep_data_done  in  NUM_IN_EPS  packet complete, arm for transmission.
REQ-011 in_ep_stall  in  NUM_IN_EPS  force endpoint to STALL.
REQ-012 in_ep_acked  out  NUM_IN_EPS  one-cycle pulse: host ACKed packet.
REQ-013 rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  rx packet strobes.
REQ-014 rx_pid  in  4; rx_addr  in  7; rx_endp  in  4  last received token fields.
REQ-015 tx_pkt_start  out  1  strobe to send a packet; tx_pid  out  4  its PID.
REQ-016 tx_pkt_end  in  1  tx path finished sending.
REQ-017 tx_data_avail  out  1  more payload bytes remain; tx_data_get  in  1  consume byte; tx_data  out  8  current byte.

Function
REQ-018 Endpoint states SHALL be FILLING, READY, STALL; reset/reset_ep -> FILLING, put pointer 0, data toggle 0.
REQ-019 FILLING: in_ep_data_free=1; each put writes buffer[ep][ptr], ptr+1; puts beyond MAX_IN_PACKET_SIZE are dropped, ptr saturates; in_ep_data_done -> READY.
REQ-020 READY: puts ignored, in_ep_data_free=0; in_ep_stall in any state -> STALL; STALL -> FILLING only on a SETUP token to that endpoint.
REQ-021 IN token: rx_pkt_end & rx_pkt_valid & rx_pid==4'b1001 & rx_addr==dev_addr & rx_endp<NUM_IN_EPS; others ignored.
REQ-022 Transfer FSM states SHALL be IDLE, RCVD_IN, SEND_DATA, WAIT_ACK; IN token in IDLE latches current_endp -> RCVD_IN.
REQ-023 RCVD_IN (one cycle): STALL -> tx_pid 4'b1110, FILLING -> NAK 4'b1010, both with tx_pkt_start and return to IDLE; READY -> DATA0 4'b0011 / DATA1 4'b1011 per toggle, tx_pkt_start, get pointer 0, -> SEND_DATA.
REQ-024 SEND_DATA: tx_data = buffer[current_endp][get_ptr] combinationally, tx_data_avail = get_ptr<put_ptr, get_ptr+1 per tx_data_get; zero-length packet gives tx_data_avail=0 immediately; tx_pkt_end -> WAIT_ACK.
REQ-025 WAIT_ACK: valid ACK (rx_pid 4'b0010) -> toggle flips, in_ep_acked pulse, endpoint FILLING with ptr 0, -> IDLE.
REQ-026 WAIT_ACK: invalid packet, non-ACK packet, or 1023-cycle timeout -> IDLE, endpoint stays READY, toggle unchanged (retry on next IN).
REQ-027 reset_ep for current_endp during SEND_DATA/WAIT_ACK SHALL abort to IDLE without in_ep_acked.
REQ-028 tx_pkt_start and tx_pid SHALL be zero except in their strobe cycle.

Reset
REQ-029 On reset all outputs 0 except in_ep_data_free all-ones; FSM IDLE; timeout counter 0; buffer contents undefined.

Structure
REQ-030 PID constants and endpoint/transfer state encodings SHALL live in a shared usb_fs_pkg, common with the OUT engine.
REQ-031 One sub-module, usb_fs_in_ep_buf (single-write/single-read byte RAM, ep-indexed), is natural; FSMs stay at top.

Verification
REQ-032 Put 3 bytes 0x11,0x22,0x33 to ep0, done; IN ep0 -> DATA0, tx bytes 11/22/33, avail low after third get; ACK -> in_ep_acked[0] pulse, free=1.
REQ-033 IN to ep0 while FILLING -> single NAK strobe, no payload, state unchanged.
REQ-034 Armed packet, IN, no ACK for 1023 cycles -> IDLE; second IN resends DATA0 same bytes; ACK -> next packet DATA1.
REQ-035 in_ep_stall[0] then IN -> STALL PID; SETUP ep0 -> FILLING, toggle 0.
REQ-036 Done with zero bytes, IN -> DATA0 with tx_data_avail=0; 40 puts with MAX=32 -> 32 bytes sent.
